// File: rtl/stair_scroller.sv
// Stair animation: draw N_STAIRS boxes, hold for FRAMES ticks, erase, move up.
// One pixel per cycle; x/y/colour/plot are registered one cycle after the scan.
module stair_scroller #(
   parameter int         W        = 40,
   parameter int         H        = 5,
   parameter int         N_STAIRS = 2,
   parameter int         X0       = 60,
   parameter int         X_STEP   = 40,
   parameter int         Y0       = 40,
   parameter int         Y_STEP   = 30,
   parameter int         Y_WRAP   = 116,
   parameter int         DELAY    = 833334,
   parameter int         FRAMES   = 4,
   parameter logic [2:0] COLOUR   = 3'b100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  logic       stop,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       moved
);

   localparam int SW = (N_STAIRS > 1) ? $clog2(N_STAIRS) : 1;
   localparam int RW = (H > 1) ? $clog2(H) : 1;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GO_WAIT,
      S_DRAW,
      S_HOLD,
      S_ERASE,
      S_UPDATE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [SW-1:0] r_si;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [DW-1:0] r_dly;
   logic [FW-1:0] r_frm;
   logic [6:0]    r_ystair [N_STAIRS];

   logic       w_scan;
   logic       w_last;
   logic       w_tick;
   logic       w_hold_done;
   logic [8:0] w_xs;
   logic [8:0] w_ys;

   assign w_last = (r_si == SW'(N_STAIRS - 1)) &&
                   (r_row == RW'(H - 1)) &&
                   (r_col == CW'(W - 1));
   assign w_tick      = (r_dly == '0);
   assign w_hold_done = w_tick && (r_frm == FW'(FRAMES - 1));

   // 9-bit sums; anything past the screen is clipped via plot
   always_comb begin
      w_xs = 9'(X0 + int'(r_si) * X_STEP + int'(r_col));
      w_ys = 9'({2'b00, r_ystair[r_si]} + 9'(r_row));
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (go)          w_next = S_GO_WAIT;
         S_GO_WAIT: if (!go)         w_next = S_DRAW;
         S_DRAW:    if (w_last)      w_next = S_HOLD;
         S_HOLD:    if (w_hold_done) w_next = S_ERASE;
         S_ERASE:   if (w_last)      w_next = stop ? S_IDLE : S_UPDATE;
         S_UPDATE:  w_next = S_DRAW;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_scan = (r_state == S_DRAW) || (r_state == S_ERASE);
      busy   = (r_state != S_IDLE);
      moved  = (r_state == S_UPDATE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_si   <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_dly  <= '0;
         r_frm  <= '0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         for (int i = 0; i < N_STAIRS; i++)
            r_ystair[i] <= 7'((Y0 + i * Y_STEP) % 128);
      end else begin
         plot <= 1'b0;
         if (w_scan) begin
            x      <= w_xs[7:0];
            y      <= w_ys[6:0];
            colour <= (r_state == S_DRAW) ? COLOUR : 3'b000;
            plot   <= (w_ys <= 9'd119) && (w_xs <= 9'd159);
            if (r_col == CW'(W - 1)) begin
               r_col <= '0;
               if (r_row == RW'(H - 1)) begin
                  r_row <= '0;
                  r_si  <= w_last ? '0 : r_si + SW'(1);
               end else begin
                  r_row <= r_row + RW'(1);
               end
            end else begin
               r_col <= r_col + CW'(1);
            end
         end
         if ((r_state == S_DRAW) && w_last) begin
            r_dly <= DW'(DELAY - 1);
            r_frm <= '0;
         end else if (r_state == S_HOLD) begin
            if (w_tick) begin
               r_dly <= DW'(DELAY - 1);
               r_frm <= w_hold_done ? '0 : r_frm + FW'(1);
            end else begin
               r_dly <= r_dly - DW'(1);
            end
         end
         if (r_state == S_UPDATE) begin
            for (int i = 0; i < N_STAIRS; i++)
               r_ystair[i] <= (r_ystair[i] == 7'd0) ? 7'(Y_WRAP)
                                                    : r_ystair[i] - 7'd1;
         end
      end
   end

endmodule

// File: tb/tb_stair_scroller.sv
// Bench for stair_scroller: three instances share clock and controls,
// differing only in start position so the scans stay in lockstep.
module tb_stair_scroller;

   logic clock;
   logic reset;
   logic go;
   logic stop;

   logic [7:0] a_x, b_x, c_x;
   logic [6:0] a_y, b_y, c_y;
   logic [2:0] a_col, b_col, c_col;
   logic       a_plot, b_plot, c_plot;
   logic       a_busy, b_busy, c_busy;
   logic       a_mv, b_mv, c_mv;

   int n_chk;
   int n_pass;
   int n_mv;

   int yam [2];
   int ybm [2];
   int ycm [2];

   logic [7:0]  cap_x  [16];
   logic [6:0]  cap_y  [16];
   logic [6:0]  cap_yb [16];
   logic [15:0] cap_pc;

   stair_scroller #(
      .W(4), .H(2), .N_STAIRS(2), .X0(10), .X_STEP(20),
      .Y0(5), .Y_STEP(3), .Y_WRAP(116), .DELAY(3), .FRAMES(2),
      .COLOUR(3'b100)
   ) u_a (
      .clock(clock), .reset(reset), .go(go), .stop(stop),
      .x(a_x), .y(a_y), .colour(a_col), .plot(a_plot),
      .busy(a_busy), .moved(a_mv)
   );

   stair_scroller #(
      .W(4), .H(2), .N_STAIRS(2), .X0(10), .X_STEP(20),
      .Y0(1), .Y_STEP(0), .Y_WRAP(116), .DELAY(3), .FRAMES(2),
      .COLOUR(3'b100)
   ) u_b (
      .clock(clock), .reset(reset), .go(go), .stop(stop),
      .x(b_x), .y(b_y), .colour(b_col), .plot(b_plot),
      .busy(b_busy), .moved(b_mv)
   );

   stair_scroller #(
      .W(4), .H(2), .N_STAIRS(2), .X0(150), .X_STEP(8),
      .Y0(118), .Y_STEP(1), .Y_WRAP(116), .DELAY(3), .FRAMES(2),
      .COLOUR(3'b100)
   ) u_c (
      .clock(clock), .reset(reset), .go(go), .stop(stop),
      .x(c_x), .y(c_y), .colour(c_col), .plot(c_plot),
      .busy(c_busy), .moved(c_mv)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial n_mv = 0;
   always @(posedge clock) if (a_mv) n_mv <= n_mv + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int nxt(input int v);
      return (v == 0) ? 116 : v - 1;
   endfunction

   task automatic move_model();
      for (int i = 0; i < 2; i++) begin
         yam[i] = nxt(yam[i]);
         ybm[i] = nxt(ybm[i]);
         ycm[i] = nxt(ycm[i]);
      end
   endtask

   task automatic reset_model();
      yam[0] = 5;   yam[1] = 8;
      ybm[0] = 1;   ybm[1] = 1;
      ycm[0] = 118; ycm[1] = 119;
   endtask

   task automatic go_pulse();
      go = 1'b1;
      @(negedge clock);
      @(negedge clock);
      go = 1'b0;
   endtask

   // counts plot=0 cycles until the next plotted pixel of instance a
   task automatic gap(input string tag, input int exp, input bit tog);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         if (tog) go = ~go;
         if (!a_plot) n++;
      end while (!a_plot && n < 60);
      chk(tag, n, exp);
   endtask

   task automatic capture(input string tag, input logic [2:0] col,
                          input bit tog);
      int i, r, c;
      int ex, ey, bx, by, qx, qy;
      logic ep, bp, qp;
      for (int p = 0; p < 16; p++) begin
         if (p > 0) begin
            @(negedge clock);
            if (tog) go = ~go;
         end
         i  = p / 8;
         r  = (p / 4) % 2;
         c  = p % 4;
         ex = 10 + 20 * i + c;
         ey = yam[i] + r;
         ep = (ex <= 159) && (ey <= 119);
         bx = ex;
         by = ybm[i] + r;
         bp = (bx <= 159) && (by <= 119);
         qx = 150 + 8 * i + c;
         qy = ycm[i] + r;
         qp = (qx <= 159) && (qy <= 119);
         cap_x[p]  = a_x;
         cap_y[p]  = a_y;
         cap_yb[p] = b_y;
         cap_pc[p] = c_plot;
         chk($sformatf("%s_a%0d", tag, p), {a_plot, a_x, a_y, a_col},
             {ep, 8'(ex), 7'(ey), col});
         chk($sformatf("%s_b%0d", tag, p), {b_plot, b_x, b_y, b_col},
             {bp, 8'(bx), 7'(by), col});
         chk($sformatf("%s_c%0d", tag, p), {c_plot, c_x, c_y, c_col},
             {qp, 8'(qx), 7'(qy), col});
      end
   endtask

   initial begin
      int m0;
      int np;
      n_chk  = 0;
      n_pass = 0;
      reset  = 1'b1;
      go     = 1'b0;
      stop   = 1'b0;
      reset_model();
      @(negedge clock);
      @(negedge clock);
      chk("rst_xy", {a_x, a_y, a_col}, 0);
      chk("rst_plot", {a_plot, b_plot, c_plot}, 0);
      chk("rst_busy", {a_busy, b_busy, c_busy}, 0);
      chk("rst_moved", {a_mv, b_mv, c_mv}, 0);

      // first draw
      reset = 1'b0;
      go_pulse();
      chk("busy_go", a_busy, 1);
      gap("g_d1", 1, 1'b0);
      capture("d1", 3'b100, 1'b0);
      chk("d1_p0", {cap_x[0], cap_y[0]}, {8'd10, 7'd5});
      chk("d1_p7", {cap_x[7], cap_y[7]}, {8'd13, 7'd6});
      chk("d1_p8", {cap_x[8], cap_y[8]}, {8'd30, 7'd8});
      chk("d1_p15", {cap_x[15], cap_y[15]}, {8'd33, 7'd9});
      chk("c_mask", cap_pc, 16'h03FF);

      // hold, erase, move
      m0 = n_mv;
      gap("hold1", 6, 1'b0);
      chk("busy_hold", a_busy, 1);
      capture("e1", 3'b000, 1'b0);
      gap("g_d2", 1, 1'b0);
      chk("mv1", n_mv - m0, 1);
      move_model();
      capture("d2", 3'b100, 1'b0);
      chk("d2_p0", {cap_x[0], cap_y[0]}, {8'd10, 7'd4});
      chk("d2_p8", {cap_x[8], cap_y[8]}, {8'd30, 7'd7});
      chk("b_m1", cap_yb[0], 0);

      gap("hold2", 6, 1'b0);
      capture("e2", 3'b000, 1'b0);
      gap("g_d3", 1, 1'b0);
      move_model();
      capture("d3", 3'b100, 1'b0);
      chk("b_m2", cap_yb[0], 116);

      // stop raised part way through hold
      m0 = n_mv;
      @(negedge clock);
      @(negedge clock);
      stop = 1'b1;
      gap("hold3", 4, 1'b0);
      capture("e3", 3'b000, 1'b0);
      @(negedge clock);
      chk("stop_plot", a_plot, 0);
      chk("stop_busy", {a_busy, b_busy, c_busy}, 0);
      chk("stop_mv", n_mv - m0, 0);
      repeat (3) @(negedge clock);
      chk("idle_busy", a_busy, 0);
      stop = 1'b0;

      // redraw at same y, then reset on the fifth draw cycle
      go_pulse();
      gap("g_d4", 1, 1'b0);
      chk("d4_p0", {a_plot, a_x, a_y, a_col}, {1'b1, 8'd10, 7'd3, 3'b100});
      chk("d4_b0", b_y, 116);
      repeat (3) @(negedge clock);
      chk("d4_p3", {a_plot, a_x, a_y}, {1'b1, 8'd13, 7'd3});
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid_plot", {a_plot, b_plot, c_plot}, 0);
      chk("mid_busy", {a_busy, b_busy, c_busy}, 0);
      np = 0;
      repeat (40) begin
         @(negedge clock);
         if (a_plot) np++;
      end
      chk("mid_quiet", np, 0);
      reset_model();

      // go toggling during hold and erase has no effect
      go_pulse();
      gap("g_d5", 1, 1'b0);
      capture("d5", 3'b100, 1'b0);
      chk("d5_p0", {cap_x[0], cap_y[0]}, {8'd10, 7'd5});
      m0 = n_mv;
      gap("hold5", 6, 1'b1);
      capture("e5", 3'b000, 1'b1);
      go = 1'b0;
      gap("g_d6", 1, 1'b0);
      chk("mv5", n_mv - m0, 1);
      move_model();
      capture("d6", 3'b100, 1'b0);
      chk("d6_p0", {cap_x[0], cap_y[0]}, {8'd10, 7'd4});
      chk("d6_p8", {cap_x[8], cap_y[8]}, {8'd30, 7'd7});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/stair_scroller.md
STAIR_SCROLLER -- requirements
Module: stair_scroller

Interface
REQ-001 The block SHALL be clocked by one clock, `clock`; reset SHALL be `reset`, synchronous and active-high, sampled only on the rising edge of `clock`.
REQ-002 Parameters SHALL be listed one per line as name, default, meaning:
- W, 40, stair width in pixels (1..160)
- H, 5, stair height in pixels (1..120)
- N_STAIRS, 2, number of stairs (1..8)
- X0, 60, x of stair 0
- X_STEP, 40, x offset between stairs
- Y0, 40, initial y of stair 0
- Y_STEP, 30, initial y offset between stairs
- Y_WRAP, 116, y reloaded after y reaches 0
- DELAY, 833334, clock cycles per frame tick
- FRAMES, 4, frame ticks between moves
- COLOUR, 3'b100, draw colour
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clock, in, 1, system clock
- reset, in, 1, sync active-high reset
- go, in, 1, start request; level, acted on at release
- stop, in, 1, level; halts animation after the current erase
- x, out, 8, pixel x
- y, out, 7, pixel y
- colour, out, 3, pixel colour
- plot, out, 1, pixel write enable
- busy, out, 1, high in every state except IDLE
- moved, out, 1, one-cycle pulse in UPDATE

Function
REQ-004 FSM states SHALL be IDLE, GO_WAIT, DRAW, HOLD, ERASE and UPDATE.
REQ-005 State transitions SHALL be:
- IDLE->GO_WAIT when go=1
- GO_WAIT->DRAW when go=0
- DRAW->HOLD after the last pixel is issued
- HOLD->ERASE after FRAMES frame ticks
- ERASE->IDLE after the last pixel if stop=1 at that cycle, else ERASE->UPDATE
- UPDATE->DRAW unconditionally after 1 cycle
REQ-006 DRAW and ERASE SHALL each scan exactly N_STAIRS*W*H cycles, one pixel per cycle.
- Stair index is the outer loop, row the middle loop, column the inner loop.
REQ-007 Pixel coordinates SHALL be computed as follows:
- Column c, row r of stair i is at x = X0 + i*X_STEP + c and y = ystair[i] + r.
- Sums SHALL be computed at 9 bits and truncated to the output width.
REQ-008 x, y, colour and plot SHALL be registered outputs; a pixel scanned in cycle k SHALL appear on the outputs in cycle k+1.
REQ-009 plot SHALL be 1 only for scanned pixels whose 9-bit y sum is at most 119 and whose x sum is at most 159.
- Off-screen pixels SHALL still consume their scan cycle, with plot=0.
REQ-010 colour SHALL be COLOUR for DRAW pixels and 3'b000 for ERASE pixels; ERASE SHALL regenerate exactly the coordinates of the preceding DRAW.
REQ-011 The delay counter SHALL behave as follows:
- It is loaded with DELAY-1 on entry to HOLD.
- It decrements each HOLD cycle.
- It produces a frame tick and reloads DELAY-1 when it reaches 0.
- The frame counter counts ticks from 0 and leaves HOLD on tick number FRAMES.
- HOLD therefore lasts DELAY*FRAMES cycles.
REQ-012 In UPDATE, every ystair[i] SHALL decrement by 1 simultaneously; a stair whose ystair[i] equals 0 SHALL reload Y_WRAP instead. moved SHALL be 1 for that cycle.
REQ-013 go SHALL be ignored in all states except IDLE and GO_WAIT; stop SHALL be sampled only on the final ERASE scan cycle.
REQ-014 On ERASE->IDLE, ystair[] SHALL keep its values; the next go restarts drawing at those positions.
REQ-015 When not in DRAW or ERASE, plot SHALL be 0 from the cycle after the last scanned pixel.
REQ-016 Parameter legality:
- DELAY>=1, FRAMES>=1 and Y_WRAP<=119 are required.
- Other combinations are covered by the REQ-009 clipping.

Reset
REQ-017 When reset=1 the block SHALL set, at the next clock edge:
- state to IDLE
- x, y, colour, plot, moved and busy to 0
- ystair[i] to (Y0 + i*Y_STEP) mod 128
- scan, delay and frame counters to 0
REQ-018 Reset asserted mid-DRAW, mid-HOLD or mid-ERASE SHALL abort the operation immediately: no further plot pulses, and no completion of the erase.
REQ-019 Reset SHALL take priority over go, stop and every state transition in the same cycle.

Verification
All scenarios use W=4, H=2, N_STAIRS=2, X0=10, X_STEP=20, Y0=5, Y_STEP=3, DELAY=3, FRAMES=2 unless stated.
REQ-020 Scenario: reset, then go high 2 cycles, then low.
- Required: 16 consecutive plot=1 cycles with colour=3'b100.
- First pixel (10,5), 8th pixel (13,6), 9th pixel (30,8), last pixel (33,9).
REQ-021 Scenario: after the first DRAW completes.
- Required: HOLD lasts exactly 6 cycles.
- Then 16 plot=1 cycles repeat the same coordinates with colour=3'b000.
- moved pulses once.
- The next DRAW starts at (10,4) and (30,7).
REQ-022 Scenario: Y0=1, Y_STEP=0, run 2 moves.
- Required: after move 1, y starts at 0.
- After move 2, y starts at 116.
- Rows with y sum above 119 have plot=0 while the scan length stays 16 cycles.
REQ-023 Scenario: stop=1 held from mid-HOLD.
- Required: the erase completes fully (16 black pixels).
- No moved pulse; state returns to IDLE; busy=0.
- The next go redraws at unchanged y.
REQ-024 Scenario: reset pulsed on the 5th DRAW cycle.
- Required: plot=0 from the next cycle; busy=0.
- A later go redraws from (10,5).
REQ-025 Scenario: go toggled during HOLD and ERASE.
- Required: no change in timing or coordinates against REQ-021.
